// File: rtl/uart_programmer_framed.sv
// Framed UART memory programmer: parses SYNC/CMD/ADDR/LEN/PAYLOAD/CSUM write packets
// from a uart_engine byte stream, streams words to memory and answers with ACK/NAK.
module uart_programmer_framed #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] START_ADDR     = 32'h0000_0800,
    parameter bit          RAW_MODE       = 1'b0,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  programmer_enable_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_done_i,
    output logic                  mem_write_enable_o,
    output logic [ADDR_WIDTH-1:0] mem_write_addr_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  busy_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [1:0]            err_code_o,
    output logic [2:0]            debug_state_o
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]         T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM, S_RESP
    } state_t;

    // Handshakes: rx_valid_i and tx_done_i are single-cycle pulses with no back-pressure;
    // a byte is consumed on the cycle rx_valid_i is high, tx_start_o is a level held until tx_done_i.
    state_t                  state;
    logic [2:0]              byte_cnt;
    logic [15:0]             words_left;
    logic [23:0]             addr_lo;
    logic [7:0]              len_lo;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   word_buf;
    logic [7:0]              csum;
    logic [TW-1:0]           tcnt;

    logic [DATA_WIDTH-1:0]   word_next;
    logic [7:0]              csum_next;
    logic                    word_done;
    logic                    in_frame;
    logic                    timed_out;

    always_comb begin
        word_next = word_buf;
        word_next[{byte_cnt, 3'b000} +: 8] = rx_data_i;
    end

    assign csum_next     = csum + rx_data_i;
    assign word_done     = (byte_cnt == 3'(DATA_BYTES - 1));
    assign in_frame      = (state inside {S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM});
    assign timed_out     = !RAW_MODE && in_frame && !rx_valid_i && (tcnt == T_LAST);
    assign busy_o        = (state != S_IDLE);
    assign debug_state_o = state;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state              <= S_IDLE;
            tx_start_o         <= 1'b0;
            tx_data_o          <= '0;
            mem_write_enable_o <= 1'b0;
            mem_write_addr_o   <= '0;
            mem_write_data_o   <= '0;
            frame_ok_o         <= 1'b0;
            frame_err_o        <= 1'b0;
            err_code_o         <= 2'd0;
            byte_cnt           <= '0;
            words_left         <= '0;
            addr_lo            <= '0;
            len_lo             <= '0;
            wr_addr            <= BASE_ADDR;
            word_buf           <= '0;
            csum               <= '0;
            tcnt               <= '0;
        end else begin
            // Write port and status strobes are zero except on the cycle they fire.
            mem_write_enable_o <= 1'b0;
            mem_write_addr_o   <= '0;
            mem_write_data_o   <= '0;
            frame_ok_o         <= 1'b0;
            frame_err_o        <= 1'b0;
            tcnt <= (in_frame && !rx_valid_i && !timed_out) ? tcnt + TW'(1) : '0;

            if (!programmer_enable_i) begin
                state      <= S_IDLE;
                tx_start_o <= 1'b0;
                tx_data_o  <= '0;
                byte_cnt   <= '0;
                words_left <= '0;
                wr_addr    <= BASE_ADDR;
                csum       <= '0;
                tcnt       <= '0;
            end else if (RAW_MODE) begin
                state <= S_PAYLOAD;
                if (rx_valid_i) begin
                    word_buf <= word_next;
                    if (word_done) begin
                        mem_write_enable_o <= 1'b1;
                        mem_write_addr_o   <= wr_addr;
                        mem_write_data_o   <= word_next;
                        wr_addr            <= wr_addr + ADDR_STEP;
                        byte_cnt           <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
            end else if (timed_out) begin
                state       <= S_RESP;
                tx_start_o  <= 1'b1;
                tx_data_o   <= NAK_BYTE;
                err_code_o  <= 2'd3;
                frame_err_o <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                        state      <= S_CMD;
                        err_code_o <= 2'd0;
                        byte_cnt   <= '0;
                        csum       <= '0;
                    end
                    S_CMD: if (rx_valid_i) begin
                        csum <= rx_data_i;
                        if (rx_data_i == 8'h01) begin
                            state <= S_ADDR;
                        end else begin
                            state       <= S_RESP;
                            tx_start_o  <= 1'b1;
                            tx_data_o   <= NAK_BYTE;
                            err_code_o  <= 2'd1;
                            frame_err_o <= 1'b1;
                        end
                    end
                    S_ADDR: if (rx_valid_i) begin
                        csum <= csum_next;
                        if (byte_cnt == 3'd3) begin
                            wr_addr  <= ADDR_WIDTH'({rx_data_i, addr_lo});
                            byte_cnt <= '0;
                            state    <= S_LEN;
                        end else begin
                            addr_lo  <= {rx_data_i, addr_lo[23:8]};
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    S_LEN: if (rx_valid_i) begin
                        csum <= csum_next;
                        if (byte_cnt == 3'd0) begin
                            len_lo   <= rx_data_i;
                            byte_cnt <= 3'd1;
                        end else begin
                            byte_cnt   <= '0;
                            words_left <= {rx_data_i, len_lo};
                            state      <= ({rx_data_i, len_lo} == 16'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: if (rx_valid_i) begin
                        csum     <= csum_next;
                        word_buf <= word_next;
                        if (word_done) begin
                            mem_write_enable_o <= 1'b1;
                            mem_write_addr_o   <= wr_addr;
                            mem_write_data_o   <= word_next;
                            wr_addr            <= wr_addr + ADDR_STEP;
                            byte_cnt           <= '0;
                            words_left         <= words_left - 16'd1;
                            if (words_left == 16'd1) state <= S_CSUM;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    S_CSUM: if (rx_valid_i) begin
                        state      <= S_RESP;
                        tx_start_o <= 1'b1;
                        if (csum_next == 8'h00) begin
                            tx_data_o  <= ACK_BYTE;
                            frame_ok_o <= 1'b1;
                        end else begin
                            tx_data_o   <= NAK_BYTE;
                            err_code_o  <= 2'd2;
                            frame_err_o <= 1'b1;
                        end
                    end
                    S_RESP: if (tx_done_i) begin
                        state      <= S_IDLE;
                        tx_start_o <= 1'b0;
                        tx_data_o  <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_programmer_framed.sv
// Bench for uart_programmer_framed: a framed 32-bit instance (short timeout) and a
// RAW_MODE 16-bit instance, checked against a frame-level model and a write scoreboard.
module tb_uart_programmer_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Framed instance
    logic        reset_n, en, rx_valid, tx_done;
    logic [7:0]  rx_data;
    logic        tx_start, mem_we, busy, frame_ok, frame_err;
    logic [7:0]  tx_data;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  err_code;
    logic [2:0]  dbg_state;

    // Raw instance
    logic        raw_en, raw_rx_valid, raw_tx_done;
    logic [7:0]  raw_rx_data;
    logic        raw_tx_start, raw_we, raw_busy, raw_ok, raw_err;
    logic [7:0]  raw_tx_data;
    logic [31:0] raw_addr;
    logic [15:0] raw_data;
    logic [1:0]  raw_err_code;
    logic [2:0]  raw_dbg;

    uart_programmer_framed #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .reset_ni(reset_n), .programmer_enable_i(en),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
        .mem_write_enable_o(mem_we), .mem_write_addr_o(mem_addr), .mem_write_data_o(mem_data),
        .busy_o(busy), .frame_ok_o(frame_ok), .frame_err_o(frame_err),
        .err_code_o(err_code), .debug_state_o(dbg_state)
    );

    uart_programmer_framed #(.DATA_WIDTH(16), .RAW_MODE(1'b1)) dut_raw (
        .clk_i(clk), .reset_ni(reset_n), .programmer_enable_i(raw_en),
        .rx_valid_i(raw_rx_valid), .rx_data_i(raw_rx_data),
        .tx_start_o(raw_tx_start), .tx_data_o(raw_tx_data), .tx_done_i(raw_tx_done),
        .mem_write_enable_o(raw_we), .mem_write_addr_o(raw_addr), .mem_write_data_o(raw_data),
        .busy_o(raw_busy), .frame_ok_o(raw_ok), .frame_err_o(raw_err),
        .err_code_o(raw_err_code), .debug_state_o(raw_dbg)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];      // {addr, data} expected from the framed instance
    logic [47:0] raw_exp_q[$];  // {addr, data} expected from the raw instance
    logic [7:0]  frame_q[$];
    logic [7:0]  last_csum;
    logic        raw_tx_seen = 1'b0;
    logic [63:0] sb_exp;
    logic [47:0] sb_raw_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("wr_word", {mem_addr, mem_data}, sb_exp);
            end
        end
        if (raw_we) begin
            if (raw_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL raw_wr_unexpected: got addr %0h data %0h expected no write", raw_addr, raw_data);
            end else begin
                sb_raw_exp = raw_exp_q.pop_front();
                check("raw_wr_word", {16'h0, raw_addr, raw_data}, {16'h0, sb_raw_exp});
            end
        end
        if (raw_tx_start || raw_tx_data != 8'h0 || raw_ok || raw_err || raw_err_code != 2'd0)
            raw_tx_seen = 1'b1;
    end

    // Frame model: payload byte p = first + 0x11*p; checksum makes CMD..CSUM sum to zero.
    task automatic build_frame(input logic [31:0] addr, input int len, input logic [7:0] first,
                               input logic [7:0] csum_delta, input int n_push);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] word;
        logic [7:0]  hdr[7];
        hdr = '{8'h01, addr[7:0], addr[15:8], addr[23:16], addr[31:24], 8'(len), 8'(len >> 8)};
        frame_q.delete();
        frame_q.push_back(8'hA5);
        sum = 8'h00;
        for (int i = 0; i < 7; i++) begin
            frame_q.push_back(hdr[i]);
            sum = sum + hdr[i];
        end
        for (int i = 0; i < len; i++) begin
            word = 32'h0;
            for (int j = 0; j < 4; j++) begin
                b = 8'(int'(first) + (i * 4 + j) * 17);
                word[j*8 +: 8] = b;
                frame_q.push_back(b);
                sum = sum + b;
            end
            if (i < n_push) exp_q.push_back({addr + 32'(i * 4), word});
        end
        last_csum = 8'h00 - sum;
        frame_q.push_back(last_csum + csum_delta);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(frame_q[i]);
    endtask

    task automatic send_raw(input logic [7:0] b);
        raw_rx_valid = 1'b1;
        raw_rx_data  = b;
        @(posedge clk); #1;
        raw_rx_valid = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [7:0] exp_b,
                               input logic [1:0] exp_err, input logic exp_ok);
        int n = 0;
        while (tx_start !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_start"}, tx_start, 1);
        check({name, "_byte"}, tx_data, exp_b);
        check({name, "_err_code"}, err_code, exp_err);
        check({name, "_pulse"}, {frame_ok, frame_err}, {exp_ok, !exp_ok});
        @(posedge clk); #1;
        check({name, "_pulse_once"}, {frame_ok, frame_err}, 0);
        // A stray byte in RESP must not start another frame.
        send_byte(8'hA5);
        @(posedge clk); #1;
        check({name, "_hold"}, {tx_start, tx_data}, {1'b1, exp_b});
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        check({name, "_done"}, {tx_start, busy, tx_data}, 0);
        check({name, "_err_held"}, err_code, exp_err);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_ctrl"}, {tx_start, tx_data, mem_we, busy, frame_ok, frame_err, err_code, dbg_state}, 0);
        check({name, "_wr"}, {mem_addr, mem_data}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; en = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; tx_done = 1'b0;
        raw_en = 1'b0; raw_rx_valid = 1'b0; raw_rx_data = 8'h0; raw_tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        check("rst_raw", {raw_tx_start, raw_tx_data, raw_we, raw_addr, raw_data, raw_busy, raw_dbg}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reference frame: model pinned against hand-computed values.
        build_frame(32'h0000_0800, 2, 8'h00, 8'h00, 2);
        check("model_csum", last_csum, 8'h19);
        check("model_w0", exp_q[0], {32'h0000_0800, 32'h3322_1100});
        check("model_w1", exp_q[1], {32'h0000_0804, 32'h7766_5544});
        send_bytes(frame_q.size());
        expect_resp("ack_a", 8'h06, 2'd0, 1'b1);

        // Bad checksum: words still written, NAK with code 2.
        build_frame(32'h0000_0800, 2, 8'h00, 8'h01, 2);
        send_bytes(frame_q.size());
        expect_resp("csum_bad", 8'h15, 2'd2, 1'b0);

        // Bad command, then a clean frame clears the error code.
        frame_q = '{8'hA5, 8'h07};
        send_bytes(2);
        expect_resp("bad_cmd", 8'h15, 2'd1, 1'b0);
        build_frame(32'h0000_1000, 1, 8'h3C, 8'h00, 1);
        send_bytes(frame_q.size());
        expect_resp("after_bad", 8'h06, 2'd0, 1'b1);

        // Timeout after two payload bytes: NAK exactly 100 cycles after the last byte.
        begin
            int n = 0;
            build_frame(32'h0000_0900, 2, 8'h80, 8'h00, 0);
            send_bytes(10);
            while (tx_start !== 1'b1 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_cycles", n, 100);
            expect_resp("timeout", 8'h15, 2'd3, 1'b0);
        end

        // Enable low mid-payload after one complete word.
        build_frame(32'h0000_0A00, 2, 8'h10, 8'h00, 1);
        send_bytes(13);
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        check_idle("abort_en");
        repeat (3) @(posedge clk);
        #1;
        check("abort_en_nowr", exp_q.size(), 0);
        build_frame(32'h0000_0B00, 1, 8'h20, 8'h00, 1);
        send_bytes(frame_q.size());
        expect_resp("after_en", 8'h06, 2'd0, 1'b1);

        // Reset mid-payload.
        build_frame(32'h0000_0C00, 2, 8'h40, 8'h00, 1);
        send_bytes(14);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_idle("abort_rst");
        build_frame(32'h0000_0D00, 2, 8'h55, 8'h00, 2);
        send_bytes(frame_q.size());
        expect_resp("after_rst", 8'h06, 2'd0, 1'b1);

        // LEN=0: ACK with no writes; address wraps modulo 2^32.
        build_frame(32'h0000_0E00, 0, 8'h00, 8'h00, 0);
        send_bytes(frame_q.size());
        expect_resp("len0", 8'h06, 2'd0, 1'b1);
        build_frame(32'hFFFF_FFFC, 2, 8'h07, 8'h00, 2);
        check("model_wrap", exp_q[1][63:32], 32'h0000_0000);
        send_bytes(frame_q.size());
        expect_resp("wrap", 8'h06, 2'd0, 1'b1);

        // RAW_MODE, 16-bit words from START_ADDR upward.
        raw_en = 1'b1;
        @(posedge clk); #1;
        check("raw_busy", raw_busy, 1);
        raw_exp_q.push_back({32'h0000_0800, 16'h1100});
        raw_exp_q.push_back({32'h0000_0802, 16'h3322});
        foreach (frame_q[i]) frame_q.delete();
        send_raw(8'h00); send_raw(8'h11); send_raw(8'h22); send_raw(8'h33);
        repeat (2) @(posedge clk);
        #1;
        check("raw_drain_a", raw_exp_q.size(), 0);
        raw_en = 1'b0;
        @(posedge clk); #1;
        check("raw_idle", {raw_busy, raw_dbg}, 0);
        raw_en = 1'b1;
        raw_exp_q.push_back({32'h0000_0800, 16'h5544});
        send_raw(8'h44); send_raw(8'h55);
        repeat (2) @(posedge clk);
        #1;
        check("raw_drain_b", raw_exp_q.size(), 0);
        check("raw_no_tx", raw_tx_seen, 0);
        check("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_programmer_framed.md
Name: uart_programmer_framed

Overview:
Parametrised successor to the raw-stream UART programmer. Consumes received bytes from a uart_engine instance and parses framed write packets: sync, command, address, length, payload and checksum. Assembles DATA_WIDTH-bit little-endian words and streams them to the instruction/data memory write port. Returns an ACK/NAK byte through the uart_engine transmitter. RAW_MODE=1 keeps the legacy unframed behaviour: bytes are written from START_ADDR upward.

Parameters:
DATA_WIDTH, 32, memory word width; multiple of 8 in the range 8..64; DATA_BYTES = DATA_WIDTH/8
ADDR_WIDTH, 32, memory address width
START_ADDR, 32'h0000_0800, base address used in RAW_MODE
RAW_MODE, 0, 1 = no framing, no responses, no timeout
SYNC_BYTE, 8'hA5, frame start marker
ACK_BYTE, 8'h06, response sent on success
NAK_BYTE, 8'h15, response sent on error
TIMEOUT_CYCLES, 5_000_000, maximum idle cycles between bytes inside a frame; must be at least 1

Ports:
clk_i  in  1  clock
reset_ni  in  1  synchronous active-low reset
programmer_enable_i  in  1  block enable; low aborts any frame synchronously
rx_valid_i  in  1  one-cycle pulse, byte received (uart_engine rx_received_o)
rx_data_i  in  8  received byte
tx_start_o  out  1  request transmission of tx_data_o
tx_data_o  out  8  response byte
tx_done_i  in  1  one-cycle pulse, response byte sent (uart_engine data_sent_o)
mem_write_enable_o  out  1  one-cycle write strobe
mem_write_addr_o  out  ADDR_WIDTH  byte address of the word
mem_write_data_o  out  DATA_WIDTH  assembled word
busy_o  out  1  high in every state except IDLE
frame_ok_o  out  1  one-cycle pulse when ACK is queued
frame_err_o  out  1  one-cycle pulse when NAK is queued
err_code_o  out  2  last error: 0 none, 1 bad command, 2 checksum, 3 timeout; held until the next frame's SYNC

Behaviour:
- Reset (reset_ni=0 at posedge): state IDLE; every output is 0, including tx_data_o and err_code_o; byte, word and timeout counters are cleared.
- Frame layout:
  - SYNC
  - CMD: 0x01 = write
  - ADDR: 4 bytes, little-endian; truncated to ADDR_WIDTH
  - LEN: 2 bytes, little-endian, counted in words
  - PAYLOAD: LEN*DATA_BYTES bytes
  - CSUM: 1 byte
- Checksum rule: the 8-bit sum of CMD..CSUM inclusive must equal 8'h00. SYNC is excluded.
- States: IDLE, CMD, ADDR, LEN, PAYLOAD, CSUM, RESP.
  - IDLE: a byte equal to SYNC_BYTE -> CMD and clears err_code_o. Any other byte is dropped.
  - CMD: 0x01 -> ADDR. Any other value -> RESP with NAK and err_code=1; no further bytes are consumed.
  - ADDR: exactly 4 bytes -> LEN.
  - LEN: exactly 2 bytes -> PAYLOAD, or -> CSUM when LEN=0.
  - PAYLOAD: bytes fill the word LSB-first. The cycle after the byte that completes a word:
    - mem_write_enable_o=1
    - mem_write_addr_o = ADDR + word_idx*DATA_BYTES (modulo 2^ADDR_WIDTH)
    - mem_write_data_o = the assembled word
    After LEN words -> CSUM.
  - CSUM: a sum of 0 -> RESP with ACK and frame_ok_o pulse. Nonzero -> RESP with NAK, err_code=2 and frame_err_o pulse.
  - RESP: tx_start_o=1 and tx_data_o stable until tx_done_i. On tx_done_i, tx_start_o drops that same cycle -> IDLE. rx bytes arriving in RESP are ignored.
- Writes are streamed, not buffered. A checksum failure does not roll back words already written; NAK tells the host to resend.
- Timeout: applies in CMD..CSUM. The counter resets on every rx_valid_i. When it reaches TIMEOUT_CYCLES -> RESP with NAK, err_code=3 and frame_err_o pulse. A partial word is discarded.
- programmer_enable_i=0: next state IDLE from any state, including RESP (tx_start_o drops). No response, no write. rx bytes are ignored while enable is low.
- Simultaneous events:
  - rx_valid_i on the same cycle as the timeout expiry: the byte wins and the counter resets.
  - tx_done_i outside RESP: ignored.
- RAW_MODE=1:
  - Always in the streaming state while enabled.
  - Word k is written to START_ADDR + k*DATA_BYTES.
  - No SYNC, checksum, timeout or tx; tx_start_o stays 0.
  - The word counter clears when enable is low or on reset.

Test Plan:
- DATA_WIDTH=32 frame A5 01 00 08 00 00 02 00, payload 00 11 22 33 44 55 66 77, correct CSUM -> writes 0x33221100 @0x0800 and 0x77665544 @0x0804; ACK 0x06 sent; err_code_o=0.
- The same frame with CSUM+1 -> both words written; NAK 0x15; err_code_o=2; frame_err_o pulses once.
- A5 07 -> immediate NAK, err_code_o=1; a following clean frame is ACKed.
- TIMEOUT_CYCLES=100: a frame stalls after 2 payload bytes -> NAK on cycle 100 after the last byte; no write; busy_o=0 after tx_done_i.
- RAW_MODE=1, DATA_WIDTH=16, bytes 00 11 22 33 -> 0x1100 @0x0800, 0x3322 @0x0802; tx_start_o never asserted.
- Mid-payload: programmer_enable_i low for 1 cycle, and separately reset_ni low for 1 cycle -> IDLE, all outputs 0, no write; the next frame completes normally; LEN=0 frame -> ACK with no writes.
